// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS FSM controller driving the datapath load/select/write strobes.
// Optional exception states (invalid opcode, overflow) are built when CONTROL_EXCEPTIONS_EN is defined.
module multicycle_control_unit #(
    parameter int MEM_WAIT = 2,
    parameter int SP_INIT  = 227
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_overflow,
    input  logic       branch_taken,
    output logic       PC_write,
    output logic       wr,
    output logic       AB_load,
    output logic       aluout_load,
    output logic       EPC_load,
    output logic       MDR_load,
    output logic       sel_ir,
    output logic       regwrite,
    output logic       sel_alusrca,
    output logic       sel_branchop,
    output logic       sel_shift_src,
    output logic [1:0] sel_alusrcb,
    output logic [1:0] sel_shift_amt,
    output logic [2:0] sel_mux_iord,
    output logic [2:0] sel_pc_source,
    output logic [1:0] sel_regdst,
    output logic [2:0] sel_memtoreg,
    output logic [2:0] alu_op,
    output logic [2:0] sel_shift_reg,
    output logic       LSControl1,
    output logic       LSControl2,
    output logic       SSControl1,
    output logic       SSControl2,
    output logic [4:0] state_out
);
    typedef enum logic [4:0] {
        RESET, FETCH, DECODE, R_ALU, R_WB, ADDI, I_WB, SH_LD, SH_OP, SH_WB,
        MEM_ADDR, LW_RD, LW_WB, SW_WR, BRANCH, J, JAL_RA, JR
`ifdef CONTROL_EXCEPTIONS_EN
        , EXC_OP, EXC_OVF, EXC_RD, EXC_JMP
`endif
    } state_t;
    // SP_INIT is consumed by the datapath mux; the controller only selects it.
    localparam int unused_sp_init = SP_INIT;
    state_t state, state_n, illegal;
    logic [2:0] cnt;
    logic last, r_alu, r_sh;
    assign last = cnt == 3'(MEM_WAIT);
    assign r_alu = funct == 6'h20 || funct == 6'h22 || funct == 6'h24;
    assign r_sh = funct == 6'h00 || funct == 6'h02 || funct == 6'h03;
    assign state_out = state;
    assign {LSControl1, LSControl2, SSControl1, SSControl2} = 4'b0;
`ifdef CONTROL_EXCEPTIONS_EN
    logic exc_ovf;
    assign illegal = EXC_OP;
    always_ff @(posedge clk or posedge reset)
        if (reset) exc_ovf <= 1'b0;
        else exc_ovf <= state == EXC_OVF ? 1'b1 : state == EXC_OP ? 1'b0 : exc_ovf;
`else
    logic unused_ovf;
    assign unused_ovf = alu_overflow;
    assign illegal = FETCH;
`endif
    // The wait counter restarts whenever the state changes.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= RESET;
            cnt <= 3'd0;
        end else begin
            state <= state_n;
            cnt <= state_n == state ? cnt + 3'd1 : 3'd0;
        end
    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH: state_n = last ? DECODE : FETCH;
            DECODE:
                case (opcode)
                    6'h00: state_n = r_alu ? R_ALU : r_sh ? SH_LD : funct == 6'h08 ? JR : illegal;
                    6'h08: state_n = ADDI;
                    6'h23, 6'h2B: state_n = MEM_ADDR;
                    6'h04, 6'h05: state_n = BRANCH;
                    6'h02: state_n = J;
                    6'h03: state_n = JAL_RA;
                    default: state_n = illegal;
                endcase
`ifdef CONTROL_EXCEPTIONS_EN
            R_ALU: state_n = alu_overflow && funct != 6'h24 ? EXC_OVF : R_WB;
            ADDI: state_n = alu_overflow ? EXC_OVF : I_WB;
            EXC_OP, EXC_OVF: state_n = EXC_RD;
            EXC_RD: state_n = last ? EXC_JMP : EXC_RD;
`else
            R_ALU: state_n = R_WB;
            ADDI: state_n = I_WB;
`endif
            SH_LD: state_n = SH_OP;
            SH_OP: state_n = SH_WB;
            MEM_ADDR: state_n = opcode == 6'h23 ? LW_RD : SW_WR;
            LW_RD: state_n = last ? LW_WB : LW_RD;
            JAL_RA: state_n = J;
            default: state_n = FETCH;
        endcase
    end
    // Moore decode; reset forces every strobe low while it is held.
    always_comb begin
        {PC_write, wr, AB_load, aluout_load, EPC_load, MDR_load, sel_ir, regwrite} = 8'b0;
        {sel_alusrca, sel_branchop, sel_shift_src} = 3'b0;
        sel_alusrcb = 2'b00;
        sel_shift_amt = 2'b00;
        sel_mux_iord = 3'b000;
        sel_pc_source = 3'b000;
        sel_regdst = 2'b00;
        sel_memtoreg = 3'b000;
        alu_op = 3'b000;
        sel_shift_reg = 3'b000;
        if (!reset)
            case (state)
                RESET: begin
                    regwrite = 1'b1;
                    sel_regdst = 2'b11;
                    sel_memtoreg = 3'b101;
                end
                FETCH: begin
                    sel_alusrcb = 2'b01;
                    alu_op = 3'b001;
                    PC_write = last;
                    sel_ir = last;
                end
                DECODE: begin
                    AB_load = 1'b1;
                    aluout_load = 1'b1;
                    sel_alusrcb = 2'b11;
                    alu_op = 3'b001;
                end
                R_ALU: begin
                    sel_alusrca = 1'b1;
                    aluout_load = 1'b1;
                    alu_op = funct == 6'h22 ? 3'b010 : funct == 6'h24 ? 3'b011 : 3'b001;
                end
                R_WB: begin
                    regwrite = 1'b1;
                    sel_regdst = 2'b01;
                end
                ADDI, MEM_ADDR: begin
                    sel_alusrca = 1'b1;
                    sel_alusrcb = 2'b10;
                    alu_op = 3'b001;
                    aluout_load = 1'b1;
                end
                I_WB: regwrite = 1'b1;
                SH_LD: begin
                    sel_shift_reg = 3'b001;
                    sel_shift_src = 1'b1;
                end
                SH_OP: sel_shift_reg = funct == 6'h02 ? 3'b011 : funct == 6'h03 ? 3'b100 : 3'b010;
                SH_WB: begin
                    regwrite = 1'b1;
                    sel_regdst = 2'b01;
                    sel_memtoreg = 3'b010;
                end
                LW_RD: begin
                    sel_mux_iord = 3'b001;
                    MDR_load = last;
                end
                LW_WB: begin
                    regwrite = 1'b1;
                    sel_memtoreg = 3'b001;
                end
                SW_WR: begin
                    sel_mux_iord = 3'b001;
                    wr = 1'b1;
                end
                BRANCH: begin
                    sel_alusrca = 1'b1;
                    alu_op = 3'b111;
                    sel_branchop = opcode == 6'h05;
                    sel_pc_source = 3'b001;
                    PC_write = branch_taken;
                end
                J: begin
                    PC_write = 1'b1;
                    sel_pc_source = 3'b010;
                end
                JAL_RA: begin
                    regwrite = 1'b1;
                    sel_regdst = 2'b10;
                    sel_memtoreg = 3'b100;
                end
                JR: begin
                    PC_write = 1'b1;
                    sel_pc_source = 3'b100;
                end
`ifdef CONTROL_EXCEPTIONS_EN
                EXC_OP, EXC_OVF: begin
                    EPC_load = 1'b1;
                    sel_alusrcb = 2'b01;
                    alu_op = 3'b010;
                    sel_mux_iord = state == EXC_OVF ? 3'b011 : 3'b010;
                end
                EXC_RD: begin
                    sel_mux_iord = exc_ovf ? 3'b011 : 3'b010;
                    MDR_load = last;
                end
                EXC_JMP: begin
                    PC_write = 1'b1;
                    sel_pc_source = 3'b011;
                end
`endif
                default: ;
            endcase
    end
endmodule
